// File: rtl/pkt_buf_scheduler.sv
// Triple-buffered packet store: the writer fills one bank, the reader shows another,
// and the spare bank carries the newest committed frame until the next frame boundary.
module pkt_buf_scheduler #(
  parameter int DEPTH = 1500,
  parameter int AW    = 11,
  parameter int CW    = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          wr_commit,
  input  logic [15:0]   wr_len,
  input  logic          rd_frame_done,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [15:0]   rd_len,
  output logic          rd_valid,
  output logic [CW-1:0] frame_count,
  output logic [CW-1:0] drop_count,
  output logic          len_err
);

  localparam int            MW      = $clog2(3 * DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [15:0]   DEPTH_L = 16'(DEPTH);

  logic [7:0]    mem [3*DEPTH];

  logic [1:0]    wr_bank_q, wr_bank_d;
  logic [1:0]    rd_bank_q, rd_bank_d;
  logic [1:0]    spare_bank_q, spare_bank_d;
  logic          ready_valid_q, ready_valid_d;
  logic [15:0]   ready_len_q, ready_len_d;
  logic [15:0]   rd_len_q, rd_len_d;
  logic          rd_valid_q, rd_valid_d;
  logic [CW-1:0] frame_count_q, frame_count_d;
  logic [CW-1:0] drop_count_q, drop_count_d;
  logic          len_err_q, len_err_d;
  logic [7:0]    rd_data_q;

  logic [15:0]   commit_len;
  logic          drop_inc;
  logic          wr_hit, rd_hit;
  logic [MW-1:0] wr_idx, rd_idx;

  assign wr_hit = wr_en && (wr_addr < DEPTH_A);
  assign rd_hit = rd_addr < DEPTH_A;
  assign wr_idx = MW'(wr_bank_q) * MW'(DEPTH) + MW'(wr_addr);
  assign rd_idx = MW'(rd_bank_q) * MW'(DEPTH) + MW'(rd_addr);

  // NOTE: the payload array has no reset; its contents are don't-care after reset and a clear would prevent block RAM inference.
  always_ff @(posedge sys_clk) begin
    if (wr_hit) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rd_data_q <= 8'h00;
    else         rd_data_q <= rd_hit ? mem[rd_idx] : 8'h00;
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave a signal unassigned and infer a latch.
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    spare_bank_d  = spare_bank_q;
    ready_valid_d = ready_valid_q;
    ready_len_d   = ready_len_q;
    rd_len_d      = rd_len_q;
    rd_valid_d    = rd_valid_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    len_err_d     = len_err_q;

    commit_len = (wr_len > DEPTH_L) ? DEPTH_L : wr_len;
    drop_inc   = ready_valid_q && (drop_count_q != '1);

    if (wr_commit && (wr_len > DEPTH_L)) len_err_d = 1'b1;

    case ({wr_commit, rd_frame_done})
      2'b10: begin
        wr_bank_d     = spare_bank_q;
        spare_bank_d  = wr_bank_q;
        ready_valid_d = 1'b1;
        ready_len_d   = commit_len;
        if (drop_inc) drop_count_d = drop_count_q + 1'b1;
      end
      2'b01: begin
        // Without a pending frame the reader simply repeats the current one.
        if (ready_valid_q) begin
          rd_bank_d     = spare_bank_q;
          spare_bank_d  = rd_bank_q;
          ready_valid_d = 1'b0;
          rd_len_d      = ready_len_q;
          rd_valid_d    = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
        end
      end
      2'b11: begin
        // The frame committed this cycle goes straight to the reader; any pending one is skipped.
        rd_bank_d     = wr_bank_q;
        wr_bank_d     = spare_bank_q;
        spare_bank_d  = rd_bank_q;
        ready_valid_d = 1'b0;
        rd_len_d      = commit_len;
        rd_valid_d    = 1'b1;
        frame_count_d = frame_count_q + 1'b1;
        if (drop_inc) drop_count_d = drop_count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_bank_q     <= 2'd0;
      spare_bank_q  <= 2'd1;
      rd_bank_q     <= 2'd2;
      ready_valid_q <= 1'b0;
      ready_len_q   <= '0;
      rd_len_q      <= '0;
      rd_valid_q    <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      len_err_q     <= 1'b0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      spare_bank_q  <= spare_bank_d;
      rd_bank_q     <= rd_bank_d;
      ready_valid_q <= ready_valid_d;
      ready_len_q   <= ready_len_d;
      rd_len_q      <= rd_len_d;
      rd_valid_q    <= rd_valid_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      len_err_q     <= len_err_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_len      = rd_len_q;
  assign rd_valid    = rd_valid_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_pkt_buf_scheduler.sv
// Bench for pkt_buf_scheduler: directed frames with literal expectations, then random
// traffic checked every cycle against a frame-role model (writing / pending / displayed).
module tb_pkt_buf_scheduler;

  localparam int DEPTH = 1500;
  localparam int AW    = 11;
  localparam int CW    = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_commit;
  logic [15:0]   wr_len;
  logic          rd_frame_done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [15:0]   rd_len;
  logic          rd_valid;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;
  logic          len_err;

  pkt_buf_scheduler #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_commit     (wr_commit),
    .wr_len        (wr_len),
    .rd_frame_done (rd_frame_done),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_len        (rd_len),
    .rd_valid      (rd_valid),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .len_err       (len_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: contents of the frame being written, the pending frame and the displayed frame (-1 = unknown).
  int wbuf [DEPTH];
  int pbuf [DEPTH];
  int dbuf [DEPTH];
  int tbuf [DEPTH];
  int m_rd_data, m_ready_len, m_rd_len, m_fc, m_dc;
  bit m_ready_valid, m_rd_valid, m_len_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int l;
    if (sys_rst) begin
      m_rd_data = 0; m_ready_valid = 0; m_ready_len = 0; m_rd_len = 0;
      m_rd_valid = 0; m_fc = 0; m_dc = 0; m_len_err = 0;
      foreach (wbuf[i]) begin wbuf[i] = -1; pbuf[i] = -1; dbuf[i] = -1; end
      return;
    end
    m_rd_data = (int'(rd_addr) < DEPTH) ? dbuf[rd_addr] : 0;
    if (wr_en && int'(wr_addr) < DEPTH) wbuf[wr_addr] = int'(wr_data);
    l = (int'(wr_len) > DEPTH) ? DEPTH : int'(wr_len);
    if (wr_commit && int'(wr_len) > DEPTH) m_len_err = 1;
    if (wr_commit && !rd_frame_done) begin
      tbuf = wbuf; wbuf = pbuf; pbuf = tbuf;
      if (m_ready_valid && m_dc < (1 << CW) - 1) m_dc++;
      m_ready_valid = 1;
      m_ready_len = l;
    end else if (rd_frame_done && !wr_commit && m_ready_valid) begin
      tbuf = dbuf; dbuf = pbuf; pbuf = tbuf;
      m_ready_valid = 0;
      m_rd_len = m_ready_len;
      m_rd_valid = 1;
      m_fc = (m_fc + 1) % (1 << CW);
    end else if (wr_commit && rd_frame_done) begin
      tbuf = dbuf; dbuf = wbuf; wbuf = pbuf; pbuf = tbuf;
      if (m_ready_valid && m_dc < (1 << CW) - 1) m_dc++;
      m_ready_valid = 0;
      m_rd_len = l;
      m_rd_valid = 1;
      m_fc = (m_fc + 1) % (1 << CW);
    end
  endtask

  task automatic compare_all();
    check("rd_valid", rd_valid, m_rd_valid);
    check("rd_len", rd_len, m_rd_len);
    check("frame_count", frame_count, m_fc);
    check("drop_count", drop_count, m_dc);
    check("len_err", len_err, m_len_err);
    if (m_rd_data >= 0) check("rd_data", rd_data, m_rd_data);
  endtask

  // Advance one clock: update the model from the applied inputs, then compare after the edge.
  task automatic step();
    model_step();
    @(posedge sys_clk);
    #2;
    compare_all();
  endtask

  task automatic clr();
    sys_rst = 0; wr_en = 0; wr_commit = 0; rd_frame_done = 0;
  endtask

  task automatic wr_byte(input int a, input int d);
    clr(); wr_en = 1; wr_addr = AW'(a); wr_data = 8'(d); step();
  endtask

  task automatic commit(input int len);
    clr(); wr_commit = 1; wr_len = 16'(len); step();
  endtask

  task automatic frame_done();
    clr(); rd_frame_done = 1; step();
  endtask

  task automatic rd_byte(input string name, input int a, input int exp);
    clr(); rd_addr = AW'(a); step();
    check(name, rd_data, exp);
  endtask

  initial begin
    clr(); rd_addr = '0; wr_addr = '0; wr_data = '0; wr_len = '0;
    sys_rst = 1; step(); step();
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_len", rd_len, 0);
    check("reset frame_count", frame_count, 0);
    check("reset drop_count", drop_count, 0);
    check("reset len_err", len_err, 0);
    check("reset rd_data", rd_data, 0);

    // First frame end to end.
    for (int i = 0; i < 4; i++) wr_byte(i, 8'hA0 + i);
    commit(4);
    frame_done();
    check("f1 rd_valid", rd_valid, 1);
    check("f1 rd_len", rd_len, 4);
    check("f1 frame_count", frame_count, 1);
    for (int i = 0; i < 4; i++) rd_byte($sformatf("f1 byte%0d", i), i, 8'hA0 + i);

    // Two commits before a frame boundary: the older one is dropped.
    for (int i = 0; i < 10; i++) wr_byte(i, 8'h10 + i);
    commit(10);
    for (int i = 0; i < 20; i++) wr_byte(i, 8'h40 + i);
    commit(20);
    frame_done();
    check("drop drop_count", drop_count, 1);
    check("drop rd_len", rd_len, 20);
    check("drop frame_count", frame_count, 2);
    rd_byte("drop byte5", 5, 8'h45);
    rd_byte("drop byte15", 15, 8'h4F);

    // Frame boundary with nothing pending: display repeats.
    frame_done();
    check("repeat rd_len", rd_len, 20);
    check("repeat frame_count", frame_count, 2);
    rd_byte("repeat byte5", 5, 8'h45);

    // Commit A, then B's last byte together with commit and frame boundary.
    for (int i = 0; i < 7; i++) wr_byte(i, 8'h60 + i);
    commit(7);
    for (int i = 0; i < 8; i++) wr_byte(i, 8'h70 + i);
    clr(); wr_en = 1; wr_addr = 11'd8; wr_data = 8'hEE;
    wr_commit = 1; wr_len = 16'd9; rd_frame_done = 1; step();
    check("cf drop_count", drop_count, 2);
    check("cf rd_len", rd_len, 9);
    check("cf frame_count", frame_count, 3);
    rd_byte("cf last byte", 8, 8'hEE);
    rd_byte("cf first byte", 0, 8'h70);

    // Oversized length and out-of-range write.
    wr_byte(0, 8'h55);
    wr_byte(1600, 8'h99);
    commit(2000);
    check("len_err set", len_err, 1);
    frame_done();
    check("clamp rd_len", rd_len, 1500);
    check("clamp frame_count", frame_count, 4);
    rd_byte("clamp byte0", 0, 8'h55);
    rd_byte("oob read", 1600, 0);
    commit(3);
    check("len_err sticky", len_err, 1);

    // Reset in the middle of a write burst.
    for (int i = 0; i < 6; i++) begin
      clr(); wr_en = 1; wr_addr = AW'(i); wr_data = 8'(8'hB0 + i);
      if (i == 3) sys_rst = 1;
      step();
      if (i == 3) check("midrst rd_data", rd_data, 0);
    end
    check("midrst rd_valid", rd_valid, 0);
    check("midrst rd_len", rd_len, 0);
    check("midrst frame_count", frame_count, 0);
    check("midrst drop_count", drop_count, 0);
    check("midrst len_err", len_err, 0);
    wr_byte(0, 8'hC0);
    wr_byte(1, 8'hC1);
    commit(2);
    frame_done();
    check("post rd_len", rd_len, 2);
    check("post frame_count", frame_count, 1);
    rd_byte("post byte0", 0, 8'hC0);
    rd_byte("post byte1", 1, 8'hC1);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      clr();
      sys_rst       = ($urandom_range(0, 799) == 0);
      wr_en         = 1'($urandom_range(0, 1));
      wr_addr       = ($urandom_range(0, 9) != 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 2047));
      wr_data       = 8'($urandom);
      wr_commit     = ($urandom_range(0, 11) == 0);
      wr_len        = 16'($urandom_range(0, 2100));
      rd_frame_done = ($urandom_range(0, 15) == 0);
      rd_addr       = ($urandom_range(0, 9) != 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 2047));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
